// File: rtl/pipeline_rf_pkg.sv
// Shared constants and helpers for the decode-stage register file.
// Default widths, read-port count and packed-port slice offsets.
package pipeline_rf_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;

   // Low bit of port `port` inside a packed bus of `width`-bit lanes.
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits for hazard detection in the decode stage.
// Ports: i_clk, i_rst (sync, active-high), i_clk_enable,
//   i_wr_en_0/1 + i_wr_addr_0/1 (clear), i_claim_en + i_claim_addr (set),
//   i_rd_addr (packed read addresses), o_rd_busy (one bit per read port).
module reg_file_scoreboard
   import pipeline_rf_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clk_enable,
   input  logic                     i_wr_en_0,
   input  logic [ADDR_W-1:0]        i_wr_addr_0,
   input  logic                     i_wr_en_1,
   input  logic [ADDR_W-1:0]        i_wr_addr_1,
   input  logic                     i_claim_en,
   input  logic [ADDR_W-1:0]        i_claim_addr,
   input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
   output logic [NUM_RD-1:0]        o_rd_busy
);

   localparam int NUM_REGS = 1 << ADDR_W;

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Claim is applied after the clears so a new producer wins.
   always_comb begin
      busy_d = busy_q;
      if (i_clk_enable) begin
         if (i_wr_en_0) busy_d[i_wr_addr_0] = 1'b0;
         if (i_wr_en_1) busy_d[i_wr_addr_1] = 1'b0;
         if (i_claim_en) busy_d[i_claim_addr] = 1'b1;
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      localparam int LO = slice_lo(k, ADDR_W);
      logic [ADDR_W-1:0] ra;
      logic              hit;
      logic              busy;

      assign ra = i_rd_addr[LO +: ADDR_W];

      // A same-cycle write retires the old producer; only a
      // coincident claim on that register keeps it pending.
      always_comb begin
         hit  = (i_wr_en_0 && (i_wr_addr_0 == ra))
              || (i_wr_en_1 && (i_wr_addr_1 == ra));
         busy = busy_q[ra];
         if ((BYPASS != 0) && i_clk_enable && hit)
            busy = i_claim_en && (i_claim_addr == ra);
         if ((ZERO_REG != 0) && (ra == '0)) busy = 1'b0;
      end

      assign o_rd_busy[k] = busy;
   end

endmodule

// File: rtl/pipeline_reg_file.sv
// Architectural register file: NUM_RD read ports, two write ports,
// optional write-to-read bypass and a busy-bit scoreboard.
// Ports: i_clk, i_rst (sync, active-high), i_clk_enable (stall gate),
//   i_rd_addr -> o_rd_data / o_rd_busy (packed, combinational),
//   i_wr_en/addr/data_0 (older), i_wr_en/addr/data_1 (younger),
//   i_claim_en/i_claim_addr (mark destination pending).
module pipeline_reg_file
   import pipeline_rf_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clk_enable,
   input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] o_rd_data,
   output logic [NUM_RD-1:0]        o_rd_busy,
   input  logic                     i_wr_en_0,
   input  logic [ADDR_W-1:0]        i_wr_addr_0,
   input  logic [DATA_W-1:0]        i_wr_data_0,
   input  logic                     i_wr_en_1,
   input  logic [ADDR_W-1:0]        i_wr_addr_1,
   input  logic [DATA_W-1:0]        i_wr_data_1,
   input  logic                     i_claim_en,
   input  logic [ADDR_W-1:0]        i_claim_addr
);

   localparam int NUM_REGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   // Port 1 is written last so the younger instruction wins a collision.
   always_comb begin
      regs_d = regs_q;
      if (i_clk_enable) begin
         if (i_wr_en_0) regs_d[i_wr_addr_0] = i_wr_data_0;
         if (i_wr_en_1) regs_d[i_wr_addr_1] = i_wr_data_1;
      end
      if (ZERO_REG != 0) regs_d[0] = '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) regs_q <= '{default: '0};
      else       regs_q <= regs_d;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      localparam int ALO = slice_lo(k, ADDR_W);
      localparam int DLO = slice_lo(k, DATA_W);
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdata;
      logic              hit_0;
      logic              hit_1;

      assign ra = i_rd_addr[ALO +: ADDR_W];

      always_comb begin
         hit_0 = i_wr_en_0 && (i_wr_addr_0 == ra);
         hit_1 = i_wr_en_1 && (i_wr_addr_1 == ra);
         rdata = regs_q[ra];
         if ((BYPASS != 0) && i_clk_enable) begin
            if (hit_1)      rdata = i_wr_data_1;
            else if (hit_0) rdata = i_wr_data_0;
         end
         if ((ZERO_REG != 0) && (ra == '0)) rdata = '0;
      end

      assign o_rd_data[DLO +: DATA_W] = rdata;
   end

   reg_file_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clk_enable (i_clk_enable),
      .i_wr_en_0    (i_wr_en_0),
      .i_wr_addr_0  (i_wr_addr_0),
      .i_wr_en_1    (i_wr_en_1),
      .i_wr_addr_1  (i_wr_addr_1),
      .i_claim_en   (i_claim_en),
      .i_claim_addr (i_claim_addr),
      .i_rd_addr    (i_rd_addr),
      .o_rd_busy    (o_rd_busy)
   );

endmodule
